// File: rtl/score_keeper_if.sv
// -----------------------------------------------------------------------------
// score_keeper_if
// Groups every score_keeper signal except clk and reset.
//   Controls toward the keeper : ena, start_new_game, result_valid, hit
//   Status from the keeper     : score[7:0], shots_left[3:0], streak[3:0],
//                                game_over, playing, shot_done, high_score[7:0]
// Modports:
//   master - the side that drives the controls and observes the status
//   slave  - the score keeper itself
// -----------------------------------------------------------------------------
interface score_keeper_if;
    logic       ena;
    logic       start_new_game;
    logic       result_valid;
    logic       hit;
    logic [7:0] score;
    logic [3:0] shots_left;
    logic [3:0] streak;
    logic       game_over;
    logic       playing;
    logic       shot_done;
    logic [7:0] high_score;

    modport master (
        output ena, start_new_game, result_valid, hit,
        input  score, shots_left, streak, game_over, playing, shot_done, high_score
    );

    modport slave (
        input  ena, start_new_game, result_valid, hit,
        output score, shots_left, streak, game_over, playing, shot_done, high_score
    );
endinterface

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
// Game score tracker: counts resolved shots during a game, keeps a hit streak
// that boosts the score, and ends the game when the shot budget is spent.
//
// Parameters:
//   SHOTS_PER_GAME - shots per game (1..15)
//   STREAK_MAX     - saturation value of the hit streak (0..15)
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous, active-high
//   sk    - score_keeper_if.slave: ena, start_new_game, result_valid, hit in;
//           score, shots_left, streak, game_over, playing, shot_done,
//           high_score out
// Configuration macro:
//   SCORE_KEEPER_HIGH_SCORE_EN - when defined, high_score keeps the best final
//   score since reset; when undefined high_score is constant zero.
// -----------------------------------------------------------------------------
module score_keeper #(
    parameter int SHOTS_PER_GAME = 8,
    parameter int STREAK_MAX     = 7
) (
    input  logic          clk,
    input  logic          reset,
    score_keeper_if.slave sk
);
    localparam logic [3:0] SHOTS_L  = 4'(SHOTS_PER_GAME);
    localparam logic [3:0] STREAK_L = 4'(STREAK_MAX);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t     state_q, state_d;
    logic [7:0] score_q, score_d;
    logic [3:0] shots_left_q, shots_left_d;
    logic [3:0] streak_q, streak_d;
    logic       shot_done_q, shot_done_d;
    logic       start_prev_q, rv_prev_q;
    // Set once start_new_game has been seen low after reset, so a request
    // already held high across reset release cannot start a game.
    logic       start_arm_q;

    logic       start_edge, rv_edge;
    logic [8:0] score_sum;

    assign start_edge = sk.start_new_game & ~start_prev_q & start_arm_q;
    assign rv_edge    = sk.result_valid & ~rv_prev_q;
    // 9 bits: worst case 255 + 1 + 15 still fits, bit 8 flags saturation.
    assign score_sum  = {1'b0, score_q} + 9'd1 + {5'd0, streak_q};

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        shots_left_d = shots_left_q;
        streak_d     = streak_q;
        shot_done_d  = 1'b0;
        // Start wins over a coincident shot, in every state.
        if (start_edge) begin
            state_d      = PLAY;
            score_d      = 8'd0;
            streak_d     = 4'd0;
            shots_left_d = SHOTS_L;
        end else if (state_q == PLAY && rv_edge) begin
            shot_done_d  = 1'b1;
            shots_left_d = shots_left_q - 4'd1;
            if (sk.hit) begin
                score_d  = score_sum[8] ? 8'hFF : score_sum[7:0];
                streak_d = (streak_q >= STREAK_L) ? STREAK_L : streak_q + 4'd1;
            end else begin
                streak_d = 4'd0;
            end
            if (shots_left_q == 4'd1) begin
                state_d = OVER;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            score_q      <= 8'd0;
            shots_left_q <= 4'd0;
            streak_q     <= 4'd0;
            shot_done_q  <= 1'b0;
            start_prev_q <= 1'b0;
            rv_prev_q    <= 1'b0;
            start_arm_q  <= 1'b0;
        end else if (sk.ena) begin
            state_q      <= state_d;
            score_q      <= score_d;
            shots_left_q <= shots_left_d;
            streak_q     <= streak_d;
            shot_done_q  <= shot_done_d;
            start_prev_q <= sk.start_new_game;
            rv_prev_q    <= sk.result_valid;
            if (!sk.start_new_game) begin
                start_arm_q <= 1'b1;
            end
        end else begin
            shot_done_q  <= 1'b0;
        end
    end

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    logic [7:0] high_score_q, high_score_d;

    always_comb begin
        high_score_d = high_score_q;
        if (state_q == PLAY && state_d == OVER && score_d > high_score_q) begin
            high_score_d = score_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_score_q <= 8'd0;
        end else if (sk.ena) begin
            high_score_q <= high_score_d;
        end
    end

    assign sk.high_score = high_score_q;
`else
    assign sk.high_score = 8'd0;
`endif

    assign sk.score      = score_q;
    assign sk.shots_left = shots_left_q;
    assign sk.streak     = streak_q;
    assign sk.playing    = (state_q == PLAY);
    assign sk.game_over  = (state_q == OVER);
    // The pulse is suppressed immediately while the design is disabled.
    assign sk.shot_done  = shot_done_q & sk.ena;
endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
// Scoreboard bench for score_keeper with default parameters. The driver keeps
// a rule-level model of the game and queues the expected status for every
// counted shot; a monitor pops an entry each time shot_done is seen.
// -----------------------------------------------------------------------------
module tb_score_keeper;
    localparam int N_SHOTS = 8;
    localparam int S_MAX   = 7;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    score_keeper_if sk_if ();

    score_keeper #(.SHOTS_PER_GAME(N_SHOTS), .STREAK_MAX(S_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .sk    (sk_if)
    );

    typedef struct {
        int score;
        int shots;
        int streak;
        int over;
        int play;
        int hs;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int n_pulses = 0;

    // Reference model of the game rules
    int m_score, m_shots, m_streak, m_hs;
    bit m_play, m_over, m_sp, m_rp, m_seen_low, m_sd;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int hs_expect(input int v);
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_score = 0; m_shots = 0; m_streak = 0; m_hs = 0;
        m_play = 0; m_over = 0; m_sp = 0; m_rp = 0; m_seen_low = 0; m_sd = 0;
    endtask

    // Applies the rules for one rising edge with the inputs currently driven.
    task automatic model_edge();
        bit st, rv;
        exp_t e;
        m_sd = 0;
        if (!sk_if.ena) return;
        st = sk_if.start_new_game && !m_sp && m_seen_low;
        rv = sk_if.result_valid && !m_rp;
        if (st) begin
            m_play = 1; m_over = 0;
            m_score = 0; m_streak = 0; m_shots = N_SHOTS;
        end else if (m_play && rv) begin
            m_sd = 1;
            m_shots = m_shots - 1;
            if (sk_if.hit) begin
                m_score = m_score + 1 + m_streak;
                if (m_score > 255) m_score = 255;
                m_streak = (m_streak + 1 > S_MAX) ? S_MAX : m_streak + 1;
            end else begin
                m_streak = 0;
            end
            if (m_shots == 0) begin
                m_play = 0; m_over = 1;
                if (m_score > m_hs) m_hs = m_score;
            end
        end
        m_sp = sk_if.start_new_game;
        m_rp = sk_if.result_valid;
        if (!sk_if.start_new_game) m_seen_low = 1;
        if (m_sd) begin
            e.score = m_score; e.shots = m_shots; e.streak = m_streak;
            e.over = m_over; e.play = m_play; e.hs = hs_expect(m_hs);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive(input bit en, input bit st, input bit rv, input bit h);
        sk_if.ena = en;
        sk_if.start_new_game = st;
        sk_if.result_valid = rv;
        sk_if.hit = h;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name);
        chk({name, ".score"}, int'(sk_if.score), m_score);
        chk({name, ".shots_left"}, int'(sk_if.shots_left), m_shots);
        chk({name, ".streak"}, int'(sk_if.streak), m_streak);
        chk({name, ".playing"}, int'(sk_if.playing), int'(m_play));
        chk({name, ".game_over"}, int'(sk_if.game_over), int'(m_over));
        chk({name, ".shot_done"}, int'(sk_if.shot_done), int'(m_sd && sk_if.ena));
        chk({name, ".high_score"}, int'(sk_if.high_score), hs_expect(m_hs));
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        exp_q.delete();
        #1;
        check_all(name);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_game();
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
    endtask

    task automatic shot(input bit h);
        drive(1, 0, 1, h);
        drive(1, 0, 0, 0);
    endtask

    // Monitor: one queued expectation per observed shot_done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && sk_if.shot_done) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                chk("mon.unexpected_shot_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("mon.score", int'(sk_if.score), e.score);
                chk("mon.shots_left", int'(sk_if.shots_left), e.shots);
                chk("mon.streak", int'(sk_if.streak), e.streak);
                chk("mon.game_over", int'(sk_if.game_over), e.over);
                chk("mon.playing", int'(sk_if.playing), e.play);
                chk("mon.high_score", int'(sk_if.high_score), e.hs);
            end
        end
    end

    initial begin
        int p0;
        bit hits_a[4];
        hits_a = '{1, 1, 0, 1};
        sk_if.ena = 1'b1;
        sk_if.start_new_game = 1'b0;
        sk_if.result_valid = 1'b0;
        sk_if.hit = 1'b0;
        model_reset();
        do_reset("reset0");
        drive(1, 0, 0, 0);
        check_all("post_reset");

        // Eight hits in a row
        start_game();
        check_all("start");
        chk("start.shots8", int'(sk_if.shots_left), 8);
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1, 1);
            chk("hits8.playing", int'(sk_if.playing), (i < 7) ? 1 : 0);
            drive(1, 0, 0, 0);
        end
        check_all("hits8.end");
        chk("hits8.score36", int'(sk_if.score), 36);
        chk("hits8.over", int'(sk_if.game_over), 1);
        chk("hits8.hs", int'(sk_if.high_score), hs_expect(36));

        // Shots after game end are ignored
        shot(1);
        check_all("over.ignore");

        // hit, hit, miss, hit, then finish with misses
        start_game();
        foreach (hits_a[i]) shot(hits_a[i]);
        check_all("pattern");
        chk("pattern.score4", int'(sk_if.score), 4);
        chk("pattern.streak1", int'(sk_if.streak), 1);
        chk("pattern.shots4", int'(sk_if.shots_left), 4);
        for (int i = 0; i < 4; i++) shot(0);
        check_all("gameB.end");
        chk("gameB.hs36", int'(sk_if.high_score), hs_expect(36));

        // result_valid held high for five cycles counts once
        start_game();
        p0 = n_pulses;
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 1);
        drive(1, 0, 0, 0);
        @(negedge clk);
        chk("held.pulses", n_pulses - p0, 1);
        check_all("held");
        chk("held.score1", int'(sk_if.score), 1);
        chk("held.shots7", int'(sk_if.shots_left), 7);

        // Start edge coincident with a shot edge mid-game
        shot(1);
        p0 = n_pulses;
        drive(1, 1, 1, 1);
        check_all("coinc");
        chk("coinc.score0", int'(sk_if.score), 0);
        chk("coinc.shots8", int'(sk_if.shots_left), 8);
        drive(1, 0, 0, 0);
        @(negedge clk);
        chk("coinc.no_pulse", n_pulses - p0, 0);

        // Reset mid-game after three shots
        shot(1); shot(0); shot(1);
        do_reset("midreset");
        drive(1, 0, 0, 0);
        shot(1);
        check_all("midreset.ignored");

        // start_new_game held across reset must fall before it can start
        sk_if.start_new_game = 1'b1;
        do_reset("held_start_reset");
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        check_all("held_start");
        chk("held_start.idle", int'(sk_if.playing), 0);
        start_game();
        chk("held_start.play", int'(sk_if.playing), 1);

        // Randomized play, including enable gaps
        for (int i = 0; i < 1500; i++) begin
            bit en, st, rv, h;
            en = m_sd ? 1'b1 : ($urandom_range(0, 7) != 0);
            st = ($urandom_range(0, 39) == 0);
            rv = $urandom_range(0, 1);
            h  = $urandom_range(0, 2) != 0;
            drive(en, st, rv, h);
            if ((i % 25) == 0) check_all("rand");
        end
        drive(1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("end.queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
